// File: rtl/cluster_pkg.sv
// cluster_pkg: constants and types shared by the cluster packer and the frame receiver
package cluster_pkg;
  localparam int MXADRBITS = 11;
  localparam int MXCNTBITS = 3;
  localparam int MXCLUSTERS = 8;
  localparam int MXSTRIPS = 1536;
  localparam logic [10:0] INVALID_ADR = 11'h7FF;
  typedef enum logic {IDLE, COLLECT} rx_state_e;
endpackage

// File: rtl/cluster_word_check.sv
// cluster_word_check: classifies one cluster word as sentinel, out-of-range, valid and out-of-order
module cluster_word_check #(
  parameter int MXADRBITS = cluster_pkg::MXADRBITS,
  parameter int MXSTRIPS = cluster_pkg::MXSTRIPS
) (
  input  logic [MXADRBITS-1:0] adr,
  input  logic [MXADRBITS-1:0] last_adr,
  input  logic                 seen_sentinel,
  output logic                 valid,
  output logic                 sentinel,
  output logic                 range_err,
  output logic                 order_err
);
  import cluster_pkg::*;
  assign sentinel  = adr == MXADRBITS'(INVALID_ADR);
  assign range_err = !sentinel && adr >= MXADRBITS'(MXSTRIPS);
  assign valid     = !sentinel && !range_err;
  assign order_err = valid && (seen_sentinel || adr <= last_adr);
endmodule

// File: rtl/cluster_frame_rx.sv
// cluster_frame_rx: rebuilds the parallel cluster frame from the serial link and flags
// ordering, range and truncation errors
module cluster_frame_rx #(
  parameter int MXADRBITS = cluster_pkg::MXADRBITS,
  parameter int MXCNTBITS = cluster_pkg::MXCNTBITS,
  parameter int MXCLUSTERS = cluster_pkg::MXCLUSTERS,
  parameter int MXSTRIPS = cluster_pkg::MXSTRIPS,
  parameter int ERRCNTBITS = 16
) (
  input  logic                            clock4x,
  input  logic                            reset,
  input  logic                            frame_start,
  input  logic                            word_valid,
  input  logic [MXADRBITS-1:0]            adr_in,
  input  logic [MXCNTBITS-1:0]            cnt_in,
  output logic [MXCLUSTERS*MXADRBITS-1:0] adr_out,
  output logic [MXCLUSTERS*MXCNTBITS-1:0] cnt_out,
  output logic [MXCLUSTERS-1:0]           vpf_out,
  output logic                            frame_valid,
  output logic [3:0]                      cluster_count,
  output logic                            err_order,
  output logic                            err_range,
  output logic                            err_trunc,
  output logic [ERRCNTBITS-1:0]           err_cnt
);
  import cluster_pkg::*;
  localparam int IW = $clog2(MXCLUSTERS);
  localparam int AW = MXCLUSTERS*MXADRBITS;
  localparam int CW = MXCLUSTERS*MXCNTBITS;
  rx_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, slot;
  logic [AW-1:0] abuf_q, abuf_d, adr_out_q, adr_out_d;
  logic [CW-1:0] cbuf_q, cbuf_d, cnt_out_q, cnt_out_d;
  logic [MXCLUSTERS-1:0] vbuf_q, vbuf_d, vpf_q, vpf_d;
  logic [MXADRBITS-1:0] last_q, last_d;
  logic seen_q, seen_d, has_q, has_d, ord_q, ord_d, rng_q, rng_d;
  logic fv_q, fv_d, err_order_q, err_order_d, err_range_q, err_range_d, err_trunc_q, err_trunc_d;
  logic [3:0] count_q, count_d;
  logic [ERRCNTBITS-1:0] err_cnt_q, err_cnt_d;
  logic acc, start, last_slot, seen_in, has_in;
  logic w_valid, w_sent, w_range, w_chk_order, w_order;
  cluster_word_check #(.MXADRBITS(MXADRBITS), .MXSTRIPS(MXSTRIPS)) u_chk (
    .adr(adr_in), .last_adr(last_q), .seen_sentinel(seen_in),
    .valid(w_valid), .sentinel(w_sent), .range_err(w_range), .order_err(w_chk_order)
  );
  always_comb begin
    start = word_valid && frame_start;
    acc = word_valid && (frame_start || state_q == COLLECT);
    slot = start ? '0 : idx_q;
    last_slot = acc && slot == IW'(MXCLUSTERS-1);
    seen_in = !start && seen_q;
    has_in = !start && has_q;
    // the first valid word of a frame has no predecessor to compare against
    w_order = w_chk_order && (seen_in || has_in);
    state_d = state_q;
    idx_d = idx_q;
    abuf_d = abuf_q;
    cbuf_d = cbuf_q;
    vbuf_d = vbuf_q;
    last_d = last_q;
    seen_d = seen_q;
    has_d = has_q;
    ord_d = ord_q;
    rng_d = rng_q;
    if (acc) begin
      abuf_d[int'(slot)*MXADRBITS +: MXADRBITS] = adr_in;
      cbuf_d[int'(slot)*MXCNTBITS +: MXCNTBITS] = cnt_in;
      vbuf_d = start ? '0 : vbuf_q;
      vbuf_d[slot] = w_valid;
      ord_d = (!start && ord_q) || w_order;
      rng_d = (!start && rng_q) || w_range;
      seen_d = seen_in || w_sent;
      has_d = has_in || w_valid;
      last_d = w_valid ? adr_in : last_q;
      idx_d = last_slot ? '0 : slot + IW'(1);
      state_d = last_slot ? IDLE : COLLECT;
    end
    fv_d = last_slot;
    err_trunc_d = start && state_q == COLLECT;
    adr_out_d = last_slot ? abuf_d : adr_out_q;
    cnt_out_d = last_slot ? cbuf_d : cnt_out_q;
    vpf_d = last_slot ? vbuf_d : vpf_q;
    count_d = last_slot ? 4'($countones(vbuf_d)) : count_q;
    err_order_d = last_slot ? ord_d : err_order_q;
    err_range_d = last_slot ? rng_d : err_range_q;
    err_cnt_d = ((err_trunc_d || (last_slot && (ord_d || rng_d))) && !(&err_cnt_q)) ?
                err_cnt_q + ERRCNTBITS'(1) : err_cnt_q;
  end
  always_ff @(posedge clock4x) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      abuf_q <= {MXCLUSTERS{MXADRBITS'(INVALID_ADR)}};
      cbuf_q <= '0;
      vbuf_q <= '0;
      last_q <= '0;
      seen_q <= 1'b0;
      has_q <= 1'b0;
      ord_q <= 1'b0;
      rng_q <= 1'b0;
      adr_out_q <= {MXCLUSTERS{MXADRBITS'(INVALID_ADR)}};
      cnt_out_q <= '0;
      vpf_q <= '0;
      count_q <= '0;
      fv_q <= 1'b0;
      err_order_q <= 1'b0;
      err_range_q <= 1'b0;
      err_trunc_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      abuf_q <= abuf_d;
      cbuf_q <= cbuf_d;
      vbuf_q <= vbuf_d;
      last_q <= last_d;
      seen_q <= seen_d;
      has_q <= has_d;
      ord_q <= ord_d;
      rng_q <= rng_d;
      adr_out_q <= adr_out_d;
      cnt_out_q <= cnt_out_d;
      vpf_q <= vpf_d;
      count_q <= count_d;
      fv_q <= fv_d;
      err_order_q <= err_order_d;
      err_range_q <= err_range_d;
      err_trunc_q <= err_trunc_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  assign adr_out = adr_out_q;
  assign cnt_out = cnt_out_q;
  assign vpf_out = vpf_q;
  assign cluster_count = count_q;
  assign frame_valid = fv_q;
  assign err_order = err_order_q;
  assign err_range = err_range_q;
  assign err_trunc = err_trunc_q;
  assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_cluster_frame_rx.sv
// tb_cluster_frame_rx: directed and randomized frames checked against a frame-level reference model
module tb_cluster_frame_rx;
  typedef logic [10:0] fr_t [8];
  logic clock4x = 1'b0;
  logic reset, frame_start, word_valid;
  logic [10:0] adr_in;
  logic [2:0] cnt_in;
  logic [87:0] adr_out;
  logic [23:0] cnt_out;
  logic [7:0] vpf_out;
  logic frame_valid, err_order, err_range, err_trunc;
  logic [3:0] cluster_count;
  logic [15:0] err_cnt;
  int n_chk = 0, n_err = 0;
  int wq[$], cq[$];
  bit in_frame;
  logic [87:0] e_adr;
  logic [23:0] e_cnt;
  logic [7:0] e_vpf;
  logic [3:0] e_cc;
  logic e_fv, e_tr, e_ord, e_rng;
  logic [15:0] e_ec;
  fr_t f1, f2, f3, fr;

  cluster_frame_rx dut (
    .clock4x(clock4x), .reset(reset), .frame_start(frame_start), .word_valid(word_valid),
    .adr_in(adr_in), .cnt_in(cnt_in), .adr_out(adr_out), .cnt_out(cnt_out), .vpf_out(vpf_out),
    .frame_valid(frame_valid), .cluster_count(cluster_count), .err_order(err_order),
    .err_range(err_range), .err_trunc(err_trunc), .err_cnt(err_cnt)
  );

  always #5 clock4x = ~clock4x;

  task automatic chk(input string tag, input logic [87:0] obs, input logic [87:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic bump();
    if (e_ec != 16'hFFFF) e_ec = e_ec + 16'd1;
  endtask

  task automatic publish();
    int last;
    bit seen;
    last = -1;
    seen = 0;
    e_ord = 0;
    e_rng = 0;
    e_vpf = '0;
    e_cc = '0;
    for (int i = 0; i < 8; i++) begin
      e_adr[i*11 +: 11] = 11'(wq[i]);
      e_cnt[i*3 +: 3] = 3'(cq[i]);
      if (wq[i] == 2047) seen = 1;
      else if (wq[i] >= 1536) e_rng = 1;
      else begin
        e_vpf[i] = 1'b1;
        e_cc = e_cc + 4'd1;
        if (seen || wq[i] <= last) e_ord = 1;
        last = wq[i];
      end
    end
    e_fv = 1;
    if (e_ord || e_rng) bump();
    wq.delete();
    cq.delete();
    in_frame = 0;
  endtask

  task automatic cyc(input logic rs, input logic fs, input logic wv, input logic [10:0] a, input logic [2:0] c);
    reset = rs;
    frame_start = fs;
    word_valid = wv;
    adr_in = a;
    cnt_in = c;
    @(posedge clock4x);
    e_fv = 0;
    e_tr = 0;
    if (rs) begin
      in_frame = 0;
      wq.delete();
      cq.delete();
      e_adr = {8{11'h7FF}};
      e_cnt = '0;
      e_vpf = '0;
      e_cc = '0;
      e_ord = 0;
      e_rng = 0;
      e_ec = '0;
    end else if (wv) begin
      if (fs) begin
        if (in_frame) begin
          e_tr = 1;
          bump();
        end
        wq.delete();
        cq.delete();
        in_frame = 1;
      end
      if (in_frame) begin
        wq.push_back(int'(a));
        cq.push_back(int'(c));
        if (wq.size() == 8) publish();
      end
    end
    #1;
    chk("frame_valid", 88'(frame_valid), 88'(e_fv));
    chk("err_trunc", 88'(err_trunc), 88'(e_tr));
    chk("err_cnt", 88'(err_cnt), 88'(e_ec));
    chk("adr_out", adr_out, e_adr);
    chk("cnt_out", 88'(cnt_out), 88'(e_cnt));
    chk("vpf_out", 88'(vpf_out), 88'(e_vpf));
    chk("cluster_count", 88'(cluster_count), 88'(e_cc));
    chk("err_order", 88'(err_order), 88'(e_ord));
    chk("err_range", 88'(err_range), 88'(e_rng));
  endtask

  task automatic send(input fr_t f, input int n, input int stall_at, input int stall_n);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) repeat (stall_n) cyc(0, 1'($urandom), 0, 11'($urandom), 3'($urandom));
      cyc(0, i == 0, 1, f[i], 3'($urandom));
    end
  endtask

  function automatic fr_t rnd_frame();
    fr_t f;
    int a, n;
    n = $urandom_range(0, 8);
    a = $urandom_range(0, 300);
    for (int i = 0; i < 8; i++) begin
      f[i] = (i < n) ? 11'((a > 2046) ? 2046 : a) : 11'h7FF;
      a = a + $urandom_range(1, 250);
    end
    if ($urandom_range(0, 3) == 0) f[$urandom_range(0, 7)] = 11'($urandom);
    return f;
  endfunction

  initial begin
    f1 = '{11'd5, 11'd40, 11'd300, 11'd1535, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF};
    f2 = '{11'd10, 11'd9, 11'd20, 11'd30, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF};
    f3 = '{11'd5, 11'd9, 11'd1600, 11'd20, 11'd30, 11'h7FF, 11'h7FF, 11'h7FF};
    cyc(1, 0, 0, 11'd0, 3'd0);
    cyc(1, 1, 1, 11'd3, 3'd1);
    cyc(0, 0, 1, 11'd7, 3'd2);
    cyc(0, 1, 0, 11'd8, 3'd2);
    send(f1, 8, 9, 0);
    chk("f1_vpf", 88'(vpf_out), 88'(8'h0F));
    chk("f1_count", 88'(cluster_count), 88'(4'd4));
    chk("f1_errcnt", 88'(err_cnt), 88'(16'd0));
    send(f2, 8, 9, 0);
    chk("f2_order", 88'(err_order), 88'(1'b1));
    chk("f2_errcnt", 88'(err_cnt), 88'(16'd1));
    chk("f2_adr01", 88'(adr_out[21:0]), 88'({11'd9, 11'd10}));
    send(f3, 8, 9, 0);
    chk("f3_range", 88'(err_range), 88'(1'b1));
    chk("f3_order", 88'(err_order), 88'(1'b0));
    chk("f3_vpf", 88'(vpf_out), 88'(8'h1B));
    send(f1, 3, 9, 0);
    send(f2, 8, 9, 0);
    chk("trunc_errcnt", 88'(err_cnt), 88'(16'd4));
    send(f1, 8, 4, 5);
    send(f3, 8, 2, 5);
    send(f1, 3, 9, 0);
    cyc(1, 0, 0, 11'd0, 3'd0);
    send(f1, 8, 9, 0);
    chk("rst_errcnt", 88'(err_cnt), 88'(16'd0));
    repeat (300) begin
      fr = rnd_frame();
      repeat ($urandom_range(0, 2)) cyc(0, 0, in_frame ? 1'b0 : 1'($urandom), 11'($urandom), 3'($urandom));
      send(fr, ($urandom_range(0, 7) == 0) ? $urandom_range(1, 7) : 8, $urandom_range(0, 9), $urandom_range(0, 3));
    end
    cyc(1, 0, 0, 11'd0, 3'd0);
    repeat (65540) cyc(0, 1, 1, 11'($urandom), 3'($urandom));
    chk("sat_errcnt", 88'(err_cnt), 88'(16'hFFFF));
    send(f2, 8, 9, 0);
    chk("sat_hold", 88'(err_cnt), 88'(16'hFFFF));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/cluster_frame_rx.md
# cluster_frame_rx

Receive end of the sorted-cluster link. Accepts the eight sorted cluster words per bunch crossing (lowest address first, unused slots carrying the 0x7FF sentinel) as a serial stream on clock4x. Rebuilds the parallel adr/cnt/vpf frame and checks the frame for ordering, range and truncation errors. Sits at the back end (trigger/readout side), directly downstream of the link that carries the cluster packer's output.

## Interface
Parameters:
- MXADRBITS, 11, cluster address width
- MXCNTBITS, 3, cluster size width
- MXCLUSTERS, 8, words per frame
- MXSTRIPS, 1536, number of legal addresses (0..MXSTRIPS-1)
- ERRCNTBITS, 16, error counter width

Ports:
- clock4x  in  1  sole clock
- reset  in  1  synchronous, active-high
- frame_start  in  1  marks word 0 of a frame; qualified by word_valid
- word_valid  in  1  adr_in/cnt_in valid this cycle
- adr_in  in  MXADRBITS  cluster address; 0x7FF = empty slot
- cnt_in  in  MXCNTBITS  cluster size
- adr_out  out  MXCLUSTERS*MXADRBITS  slot i at [i*MXADRBITS +: MXADRBITS]
- cnt_out  out  MXCLUSTERS*MXCNTBITS  slot i likewise
- vpf_out  out  MXCLUSTERS  slot i holds a valid, in-range cluster
- frame_valid  out  1  one-cycle pulse; the *_out buses hold a new frame
- cluster_count  out  4  number of set vpf_out bits
- err_order  out  1  frame had a non-ascending valid address, or a valid word after a sentinel
- err_range  out  1  frame had an address in MXSTRIPS..0x7FE
- err_trunc  out  1  one-cycle pulse: frame aborted by an early frame_start
- err_cnt  out  ERRCNTBITS  saturating count of frames with any error

## Operation
- States: IDLE, COLLECT. Slot index idx, 0..7.
- IDLE:
  - word_valid & frame_start: store the word in slot 0, idx=1, go to COLLECT.
  - word_valid without frame_start: ignore the word.
  - frame_start without word_valid: ignore.
- COLLECT:
  - word_valid & !frame_start: store the word in slot idx, idx++.
  - When slot 7 is stored, publish the frame and go to IDLE.
  - word_valid low: stall and hold state. There is no timeout.
- COLLECT with word_valid & frame_start:
  - Discard the partial frame; no frame_valid.
  - Pulse err_trunc; err_cnt++.
  - The new word becomes slot 0, idx=1, stay in COLLECT.
- Per-word check (word w):
  - sentinel: adr==0x7FF.
  - range error: adr>=MXSTRIPS and not sentinel.
  - valid: neither sentinel nor range error.
- Order check:
  - Track last valid address and a seen_sentinel flag, both reset at slot 0.
  - err_order if a valid w has adr <= last valid address, or arrives after seen_sentinel.
  - A range-error word does not update last valid address and does not set seen_sentinel.
- Publish:
  - adr_out/cnt_out carry the words exactly as received.
  - vpf_out[i] = slot i valid.
  - cluster_count = popcount(vpf_out).
  - err_order/err_range = per-frame flags.
  - err_cnt++ if either flag is set.
- err_cnt saturates at all-ones. It is cleared only by reset.

## Timing
- All outputs registered.
- Reset values:
  - adr_out all 0x7FF; cnt_out 0; vpf_out 0; cluster_count 0.
  - frame_valid, err_order, err_range, err_trunc all 0; err_cnt 0.
  - state IDLE, idx 0.
- Latency: frame_valid rises the cycle after slot 7 is accepted. Outputs hold until the next frame_valid.
- Back-to-back frames: frame_start with word_valid in the cycle right after slot 7 is accepted and starts a new frame with no dead cycle.
- err_trunc pulses the cycle after the aborting frame_start.
- Error counting coincidences:
  - Truncation and a publish cannot coincide.
  - If a truncation and a published-frame error both bump err_cnt in the same cycle, err_cnt increments by 1.
- Reset mid-frame: the partial frame is dropped and no error is counted.

## Structure
- Package cluster_pkg holds MXADRBITS, MXCNTBITS, MXCLUSTERS, MXSTRIPS and INVALID_ADR (11'h7FF), shared with the packer side.
- Sub-module cluster_word_check:
  - Combinational classification of one word.
  - Inputs: adr, last_adr, seen_sentinel.
  - Outputs: valid, sentinel, range_err, order_err.

## Test plan
- Frame with addresses 5, 40, 300, 1535, then four 0x7FF -> frame_valid one cycle after word 7; vpf_out=8'h0F, cluster_count=4, no errors, err_cnt=0.
- Addresses 10, 9, ... (descending at slot 1) -> err_order=1, err_cnt=1, adr_out still 10, 9.
- Slot 2 = 1600 -> err_range=1, vpf_out[2]=0; following valid 20 after 9 is still checked against 9.
- frame_start after 3 words -> err_trunc pulse, no frame_valid; the next 8 words publish normally.
- Two frames back-to-back, with word_valid dropped for 5 cycles mid-frame -> both frames published correctly, 8 active words each.
- Force 2^16+3 erroneous frames -> err_cnt saturates at 16'hFFFF.
